// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: argmax FSM state encoding, default widths
// and a constant clog2 helper.
package cnn_pkg;

    localparam int unsigned DEF_N_CLASS   = 7;   // matches dense_1 output width
    localparam int unsigned DEF_DATA_BITS = 16;
    localparam int unsigned DEF_CNT_BITS  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/argmax_classifier_if.sv
// Logit stream in, classification result out, plus status for the argmax stage.
interface argmax_classifier_if #(
    parameter int unsigned N_CLASS   = cnn_pkg::DEF_N_CLASS,
    parameter int unsigned DATA_BITS = cnn_pkg::DEF_DATA_BITS,
    parameter int unsigned CNT_BITS  = cnn_pkg::DEF_CNT_BITS
) ();
    localparam int unsigned IDX_BITS = cnn_pkg::clog2(N_CLASS);

    logic                 valid_i;
    logic [DATA_BITS-1:0] data_i;
    logic                 ready_o;
    logic                 valid_o;
    logic [IDX_BITS-1:0]  class_o;
    logic [DATA_BITS-1:0] score_o;
    logic                 ack_i;
    logic                 busy_o;
    logic                 overrun_o;
    logic [CNT_BITS-1:0]  count_o;

    modport slave (
        input  valid_i, data_i, ack_i,
        output ready_o, valid_o, class_o, score_o, busy_o, overrun_o, count_o
    );

    modport master (
        output valid_i, data_i, ack_i,
        input  ready_o, valid_o, class_o, score_o, busy_o, overrun_o, count_o
    );
endinterface

// File: rtl/argmax_classifier.sv
// Running argmax over N_CLASS signed logits; presents winning index/score
// through a valid/ack handshake and counts acknowledged results.
module argmax_classifier import cnn_pkg::*; #(
    parameter int unsigned N_CLASS   = DEF_N_CLASS,
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned CNT_BITS  = DEF_CNT_BITS
) (
    input  logic                clk,
    input  logic                resetn,
    argmax_classifier_if.slave  bus
);
    localparam int unsigned       IDX_BITS = clog2(N_CLASS);
    localparam logic [IDX_BITS-1:0] LAST_BEAT = IDX_BITS'(N_CLASS - 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] max_q, max_d;
    logic [IDX_BITS-1:0]  idx_q, idx_d;
    logic [IDX_BITS-1:0]  beat_q, beat_d;
    logic                 valid_q, valid_d;
    logic [IDX_BITS-1:0]  class_q, class_d;
    logic [DATA_BITS-1:0] score_q, score_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic [CNT_BITS-1:0]  count_q, count_d;

    logic ready;
    logic accept;
    logic greater;
    logic load_first;

    // Ready drops only while a result waits unacknowledged.
    assign ready   = (state_q != HOLD) || bus.ack_i;
    assign accept  = bus.valid_i && ready;
    assign greater = $signed(bus.data_i) > $signed(max_q);

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        max_d      = max_q;
        idx_d      = idx_q;
        beat_d     = beat_q;
        valid_d    = valid_q;
        class_d    = class_q;
        score_d    = score_q;
        busy_d     = busy_q;
        overrun_d  = overrun_q;
        count_d    = count_q;
        load_first = 1'b0;

        if (bus.valid_i && !ready) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_first = 1'b1;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (greater) begin
                        max_d = bus.data_i;
                        idx_d = beat_q;
                    end
                    beat_d = beat_q + 1'b1;
                    // Final beat: publish the result including this beat's compare.
                    if (beat_q == LAST_BEAT) begin
                        state_d = HOLD;
                        busy_d  = 1'b0;
                        valid_d = 1'b1;
                        class_d = greater ? beat_q : idx_q;
                        score_d = greater ? bus.data_i : max_q;
                        beat_d  = '0;
                    end
                end
            end
            HOLD: begin
                if (bus.ack_i) begin
                    valid_d = 1'b0;
                    count_d = count_q + 1'b1;
                    state_d = IDLE;
                    if (bus.valid_i) begin
                        load_first = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Logit 0 seeds the running max, so all-negative vectors work.
        if (load_first) begin
            max_d   = bus.data_i;
            idx_d   = '0;
            beat_d  = IDX_BITS'(1);
            busy_d  = 1'b1;
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            max_q     <= '0;
            idx_q     <= '0;
            beat_q    <= '0;
            valid_q   <= 1'b0;
            class_q   <= '0;
            score_q   <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            beat_q    <= beat_d;
            valid_q   <= valid_d;
            class_q   <= class_d;
            score_q   <= score_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    assign bus.ready_o   = ready;
    assign bus.valid_o   = valid_q;
    assign bus.class_o   = class_q;
    assign bus.score_o   = score_q;
    assign bus.busy_o    = busy_q;
    assign bus.overrun_o = overrun_q;
    assign bus.count_o   = count_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed and random logit vectors
// checked against a plain argmax model.
module tb_argmax_classifier;
    import cnn_pkg::*;

    localparam int unsigned N  = 7;
    localparam int unsigned DW = 16;
    // Counter narrowed so the wrap point is reachable in a short run.
    localparam int unsigned CW = 10;
    localparam int unsigned IW = clog2(N);

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    argmax_classifier_if #(.N_CLASS(N), .DATA_BITS(DW), .CNT_BITS(CW)) bus ();

    argmax_classifier #(.N_CLASS(N), .DATA_BITS(DW), .CNT_BITS(CW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad = 0;
    int exp_count = 0;
    logic signed [DW-1:0] vec [N];
    int e_idx;
    int e_sc;

    // Reference argmax: first occurrence of the largest signed value.
    function automatic void model();
        e_idx = 0;
        e_sc  = int'(vec[0]);
        for (int i = 1; i < int'(N); i++) begin
            if (int'(vec[i]) > e_sc) begin
                e_sc  = int'(vec[i]);
                e_idx = i;
            end
        end
    endfunction

    function automatic void rand_vec(input int lo, input int hi);
        for (int i = 0; i < int'(N); i++) begin
            vec[i] = DW'(lo + int'($urandom_range(hi - lo)));
        end
    endfunction

    // Drives vec[] with optional random gaps; ack drops after the first edge
    // unless keep_ack is set. Starts and ends on a negedge.
    task automatic drive_vector(input int gap_pct, input bit keep_ack);
        for (int i = 0; i < int'(N); i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                bus.valid_i = 1'b0;
                bus.data_i  = DW'($urandom);
                @(negedge clk);
                if (!keep_ack) bus.ack_i = 1'b0;
            end
            bus.valid_i = 1'b1;
            bus.data_i  = vec[i];
            @(negedge clk);
            if (!keep_ack) bus.ack_i = 1'b0;
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.valid_i = 1'b0; bus.data_i = '0; bus.ack_i = 1'b0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.valid_o); end
        total++; if (bus.class_o !== '0) begin bad++; $display("FAIL reset_class got=%0d want=0", bus.class_o); end
        total++; if (bus.score_o !== '0) begin bad++; $display("FAIL reset_score got=%0d want=0", bus.score_o); end
        total++; if (bus.busy_o !== 1'b0 || bus.overrun_o !== 1'b0) begin bad++; $display("FAIL reset_flags got busy=%0b ovr=%0b want 0 0", bus.busy_o, bus.overrun_o); end
        total++; if (bus.count_o !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count_o); end
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", bus.ready_o); end
        resetn = 1'b1;
        exp_count = 0;
        @(negedge clk);
    endtask

    task automatic test_ties();
        vec = '{16'sd3, -16'sd1, 16'sd10, 16'sd2, 16'sd10, 16'sd0, -16'sd5};
        model();
        bus.ack_i = 1'b1;
        drive_vector(0, 1'b1);
        total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL ties_valid got=%0b want=1", bus.valid_o); end
        total++; if (bus.class_o !== IW'(e_idx)) begin bad++; $display("FAIL ties_class got=%0d want=%0d", bus.class_o, e_idx); end
        total++; if (bus.score_o !== DW'(e_sc)) begin bad++; $display("FAIL ties_score got=%0d want=%0d", $signed(bus.score_o), e_sc); end
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL ties_busy got=%0b want=0", bus.busy_o); end
        @(negedge clk);
        exp_count++;
        bus.ack_i = 1'b0;
        total++; if (bus.count_o !== CW'(exp_count)) begin bad++; $display("FAIL ties_count got=%0d want=%0d", bus.count_o, exp_count); end
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL ties_valid_clr got=%0b want=0", bus.valid_o); end
    endtask

    task automatic test_negative();
        vec = '{-16'sd8, -16'sd3, -16'sd20, -16'sd3, -16'sd9, -16'sd100, -16'sd4};
        model();
        bus.ack_i = 1'b0;
        drive_vector(0, 1'b0);
        @(negedge clk);
        total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL neg_valid got=%0b want=1", bus.valid_o); end
        total++; if (bus.class_o !== IW'(e_idx)) begin bad++; $display("FAIL neg_class got=%0d want=%0d", bus.class_o, e_idx); end
        total++; if (bus.score_o !== DW'(e_sc)) begin bad++; $display("FAIL neg_score got=%0d want=%0d", $signed(bus.score_o), e_sc); end
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        exp_count++;
        total++; if (bus.count_o !== CW'(exp_count)) begin bad++; $display("FAIL neg_count got=%0d want=%0d", bus.count_o, exp_count); end
    endtask

    task automatic test_gaps();
        rand_vec(-32768, 32766);
        vec[N-1] = 16'sh7FFF;
        model();
        bus.ack_i = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (i > 0 && (i == 3 || $urandom_range(1) == 1)) begin
                bus.valid_i = 1'b0;
                bus.data_i  = DW'($urandom);
                @(negedge clk);
                total++; if (bus.busy_o !== 1'b1 || bus.valid_o !== 1'b0) begin bad++; $display("FAIL gap_frozen beat=%0d got busy=%0b valid=%0b want 1 0", i, bus.busy_o, bus.valid_o); end
            end
            bus.valid_i = 1'b1;
            bus.data_i  = vec[i];
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        total++; if (bus.class_o !== IW'(e_idx) || bus.valid_o !== 1'b1) begin bad++; $display("FAIL gap_class got=%0d valid=%0b want=%0d 1", bus.class_o, bus.valid_o, e_idx); end
        total++; if (bus.score_o !== DW'(e_sc)) begin bad++; $display("FAIL gap_score got=%0d want=%0d", $signed(bus.score_o), e_sc); end
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        exp_count++;
        total++; if (bus.count_o !== CW'(exp_count)) begin bad++; $display("FAIL gap_count got=%0d want=%0d", bus.count_o, exp_count); end
    endtask

    task automatic test_hold_overrun();
        int s_idx;
        int s_sc;
        rand_vec(-32768, 32767);
        model();
        s_idx = e_idx;
        s_sc  = e_sc;
        bus.ack_i = 1'b0;
        drive_vector(20, 1'b0);
        for (int c = 0; c < 5; c++) begin
            bus.valid_i = (c % 2 == 0);
            bus.data_i  = DW'($urandom);
            #1;
            total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL hold_ready cyc=%0d got=%0b want=0", c, bus.ready_o); end
            @(negedge clk);
            total++; if (bus.valid_o !== 1'b1 || bus.class_o !== IW'(s_idx) || bus.score_o !== DW'(s_sc)) begin bad++; $display("FAIL hold_stable cyc=%0d got v=%0b c=%0d s=%0d want 1 %0d %0d", c, bus.valid_o, bus.class_o, $signed(bus.score_o), s_idx, s_sc); end
            total++; if (bus.overrun_o !== 1'b1) begin bad++; $display("FAIL overrun_sticky cyc=%0d got=%0b want=1", c, bus.overrun_o); end
        end
        rand_vec(-32768, 32767);
        model();
        bus.valid_i = 1'b1;
        bus.data_i  = vec[0];
        bus.ack_i   = 1'b1;
        #1;
        total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL ack_ready got=%0b want=1", bus.ready_o); end
        @(negedge clk);
        bus.ack_i = 1'b0;
        exp_count++;
        total++; if (bus.count_o !== CW'(exp_count) || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin bad++; $display("FAIL ack_restart got cnt=%0d v=%0b busy=%0b want %0d 0 1", bus.count_o, bus.valid_o, bus.busy_o, exp_count); end
        for (int i = 1; i < int'(N); i++) begin
            bus.data_i = vec[i];
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        total++; if (bus.valid_o !== 1'b1 || bus.class_o !== IW'(e_idx) || bus.score_o !== DW'(e_sc)) begin bad++; $display("FAIL restart_result got v=%0b c=%0d s=%0d want 1 %0d %0d", bus.valid_o, bus.class_o, $signed(bus.score_o), e_idx, e_sc); end
        total++; if (bus.overrun_o !== 1'b1) begin bad++; $display("FAIL overrun_kept got=%0b want=1", bus.overrun_o); end
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        exp_count++;
    endtask

    task automatic test_reset_mid();
        bus.ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.valid_i = 1'b1;
            bus.data_i  = 16'h7FFF;
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        exp_count = 0;
        total++; if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.overrun_o !== 1'b0) begin bad++; $display("FAIL midrst_flags got v=%0b busy=%0b ovr=%0b want 0 0 0", bus.valid_o, bus.busy_o, bus.overrun_o); end
        total++; if (bus.class_o !== '0 || bus.score_o !== '0 || bus.count_o !== '0) begin bad++; $display("FAIL midrst_regs got c=%0d s=%0d n=%0d want 0 0 0", bus.class_o, bus.score_o, bus.count_o); end
        rand_vec(-1000, 1000);
        model();
        drive_vector(0, 1'b0);
        total++; if (bus.valid_o !== 1'b1 || bus.class_o !== IW'(e_idx) || bus.score_o !== DW'(e_sc)) begin bad++; $display("FAIL midrst_result got v=%0b c=%0d s=%0d want 1 %0d %0d", bus.valid_o, bus.class_o, $signed(bus.score_o), e_idx, e_sc); end
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        exp_count++;
        total++; if (bus.count_o !== CW'(exp_count)) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", bus.count_o, exp_count); end
    endtask

    task automatic test_back_to_back();
        bus.ack_i = 1'b0;
        for (int v = 0; v < 20; v++) begin
            if (v % 3 == 0) rand_vec(-5, 5);
            else            rand_vec(-32768, 32767);
            model();
            drive_vector(30, 1'b0);
            total++; if (bus.valid_o !== 1'b1 || bus.class_o !== IW'(e_idx) || bus.score_o !== DW'(e_sc)) begin bad++; $display("FAIL b2b_result vec=%0d got v=%0b c=%0d s=%0d want 1 %0d %0d", v, bus.valid_o, bus.class_o, $signed(bus.score_o), e_idx, e_sc); end
            total++; if (bus.count_o !== CW'(exp_count)) begin bad++; $display("FAIL b2b_count vec=%0d got=%0d want=%0d", v, bus.count_o, exp_count); end
            repeat ($urandom_range(3)) @(negedge clk);
            bus.ack_i = 1'b1;
            exp_count++;
        end
        @(negedge clk);
        bus.ack_i = 1'b0;
        total++; if (bus.count_o !== CW'(exp_count) || bus.valid_o !== 1'b0) begin bad++; $display("FAIL b2b_final got cnt=%0d v=%0b want %0d 0", bus.count_o, bus.valid_o, exp_count); end
    endtask

    task automatic test_count_wrap();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        bus.ack_i = 1'b1;
        for (int v = 0; v < (1 << CW); v++) begin
            rand_vec(-32768, 32767);
            model();
            drive_vector(0, 1'b1);
            total++; if (bus.class_o !== IW'(e_idx) || bus.score_o !== DW'(e_sc)) begin bad++; $display("FAIL wrap_result vec=%0d got c=%0d s=%0d want %0d %0d", v, bus.class_o, $signed(bus.score_o), e_idx, e_sc); end
            total++; if (bus.count_o !== CW'(v)) begin bad++; $display("FAIL wrap_count vec=%0d got=%0d want=%0d", v, bus.count_o, v); end
        end
        @(negedge clk);
        bus.ack_i = 1'b0;
        total++; if (bus.count_o !== '0 || bus.valid_o !== 1'b0) begin bad++; $display("FAIL wrap_zero got cnt=%0d v=%0b want 0 0", bus.count_o, bus.valid_o); end
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ack_i   = 1'b0;
        test_reset();
        test_ties();
        test_negative();
        test_gaps();
        test_hold_overrun();
        test_reset_mid();
        test_back_to_back();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
